// File: rtl/game_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the 9-cell board, alternates player and computer moves,
// and stops on a completed line or a full board.
module game_turn_controller #(
    parameter int unsigned PC_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_game,
    input  logic        play,
    input  logic [3:0]  player_pos,
    output logic        pc_req,
    input  logic        pc_valid,
    input  logic [3:0]  pc_pos,
    output logic [17:0] board,
    output logic        turn,
    output logic        illegal_move,
    output logic        win,
    output logic [1:0]  who,
    output logic        draw,
    output logic        game_over,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(PC_TIMEOUT + 1);
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_PC     = 2'b10;
    // Each entry packs the three cell indices of one line, one hex digit per cell.
    localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                          12'h147, 12'h258, 12'h048, 12'h246};

    typedef enum logic [2:0] {
        S_PLAYER  = 3'd0,
        S_P_CHECK = 3'd1,
        S_PC_WAIT = 3'd2,
        S_C_CHECK = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [17:0]     board_q, board_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pc_req_q, pc_req_d;
    logic            turn_q, turn_d;
    logic            illegal_q, illegal_d;
    logic            win_q, win_d;
    logic [1:0]      who_q, who_d;
    logic            draw_q, draw_d;

    logic [1:0]      win_code;
    logic            board_full;
    logic [3:0]      low_idx;
    logic            low_found;
    logic            player_legal;
    logic            pc_accept;
    logic            pc_legal;
    logic            timeout_hit;
    logic            game_ends;
    logic [1:0]      ca, cb, cc;

    // Out-of-range indices read as occupied so one compare covers both rejection cases.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        if (idx > 4'd8) return 2'b11;
        return b[2*int'(idx) +: 2];
    endfunction

    assign player_legal = (cell_at(board_q, player_pos) == 2'b00);
    assign pc_legal     = (cell_at(board_q, pc_pos) == 2'b00);
    assign pc_accept    = pc_req_q & pc_valid;
    assign timeout_hit  = (cnt_q == CW'(PC_TIMEOUT - 1));
    assign game_ends    = (win_code != 2'b00) || board_full;

    always_comb begin
        win_code = 2'b00;
        ca = 2'b00;
        cb = 2'b00;
        cc = 2'b00;
        for (int l = 0; l < 8; l++) begin
            ca = cell_at(board_q, LINES[l][11:8]);
            cb = cell_at(board_q, LINES[l][7:4]);
            cc = cell_at(board_q, LINES[l][3:0]);
            if (win_code == 2'b00 && ca != 2'b00 && ca == cb && cb == cc) win_code = ca;
        end
    end

    always_comb begin
        board_full = 1'b1;
        low_idx    = 4'd0;
        low_found  = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (board_q[2*i +: 2] == 2'b00) begin
                board_full = 1'b0;
                low_idx    = 4'(i);
                low_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || new_game) begin
            state_q   <= S_PLAYER;
            board_q   <= '0;
            cnt_q     <= '0;
            pc_req_q  <= 1'b0;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
            win_q     <= 1'b0;
            who_q     <= 2'b00;
            draw_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cnt_q     <= cnt_d;
            pc_req_q  <= pc_req_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
            win_q     <= win_d;
            who_q     <= who_d;
            draw_q    <= draw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_PLAYER:  if (play && player_legal) state_d = S_P_CHECK;
            S_P_CHECK: state_d = game_ends ? S_OVER : S_PC_WAIT;
            S_PC_WAIT: if ((pc_accept && pc_legal) || timeout_hit) state_d = S_C_CHECK;
            S_C_CHECK: state_d = game_ends ? S_OVER : S_PLAYER;
            S_OVER:    state_d = S_OVER;
            default:   state_d = S_PLAYER;
        endcase
    end

    always_comb begin
        board_d   = board_q;
        cnt_d     = cnt_q;
        pc_req_d  = pc_req_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        win_d     = win_q;
        who_d     = who_q;
        draw_d    = draw_q;
        unique case (state_q)
            S_PLAYER: begin
                if (play) begin
                    if (player_legal) board_d[2*int'(player_pos) +: 2] = CELL_PLAYER;
                    else illegal_d = 1'b1;
                end
            end
            S_P_CHECK, S_C_CHECK: begin
                if (win_code != 2'b00) begin
                    win_d = 1'b1;
                    who_d = win_code;
                end else if (board_full) begin
                    draw_d = 1'b1;
                end else if (state_q == S_P_CHECK) begin
                    pc_req_d = 1'b1;
                    turn_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    turn_d = 1'b0;
                end
            end
            S_PC_WAIT: begin
                if (pc_accept && pc_legal) begin
                    board_d[2*int'(pc_pos) +: 2] = CELL_PC;
                    pc_req_d = 1'b0;
                end else begin
                    if (pc_accept) illegal_d = 1'b1;
                    // The timeout fires on the PC_TIMEOUT-th unanswered cycle.
                    if (timeout_hit) begin
                        if (low_found) board_d[2*int'(low_idx) +: 2] = CELL_PC;
                        pc_req_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign board        = board_q;
    assign pc_req       = pc_req_q;
    assign turn         = turn_q;
    assign illegal_move = illegal_q;
    assign win          = win_q;
    assign who          = who_q;
    assign draw         = draw_q;
    assign game_over    = win_q | draw_q;
    assign dbg_state    = state_q;

endmodule
